// File: rtl/constraint_sample_harvester.sv
// Drives pseudo-random candidates into a combinational constraint checker and collects satisfying ones in a FIFO.
// Optional macro HARVEST_DEDUP_LAST_EN: skip a satisfying candidate equal to the last pushed vector.
module constraint_sample_harvester #(
    parameter int VEC_W      = 224,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      seed_i,
    input  logic             start,
    input  logic [CNT_W-1:0] max_trials,
    input  logic [CNT_W-1:0] target_accepts,
    output logic [VEC_W-1:0] cand_o,
    input  logic             sat_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [CNT_W-1:0] accept_cnt
);
    localparam int LANES = (VEC_W + 31) / 32;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state;

    logic [LANES*32-1:0] lanes;
    logic [LANES*32-1:0] lanes_step;
    logic [LANES*32-1:0] lanes_seed;

    logic [CNT_W-1:0] max_r;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] trial_next;
    logic [CNT_W-1:0] accept_next;

    logic [VEC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic pop;
    logic push;
    logic full_after_pop;
    logic want_push;
    logic stall;
    logic trial;
    logic is_dup;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int k);
        logic [31:0] s;
        s = seed ^ (32'(k) * GOLDEN);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    always_comb begin
        lanes_step = '0;
        lanes_seed = '0;
        for (int k = 0; k < LANES; k++) begin
            lanes_step[k*32 +: 32] = lfsr_next(lanes[k*32 +: 32]);
            lanes_seed[k*32 +: 32] = lane_seed(seed_i, k);
        end
    end

    assign cand_o = lanes[VEC_W-1:0];

    assign out_valid      = (count != '0);
    assign out_data       = mem[rd_ptr];
    assign pop            = out_valid && out_ready;
    assign full_after_pop = (count == COUNT_FULL) && !pop;

`ifdef HARVEST_DEDUP_LAST_EN
    logic [VEC_W-1:0] last_vec;
    logic             last_valid;

    assign is_dup = last_valid && (last_vec == cand_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_vec   <= '0;
        end else if (state == IDLE && start) begin
            last_valid <= 1'b0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_vec   <= cand_o;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // A duplicate needs no FIFO slot, so only a real push can stall the trial stream.
    assign want_push = (state == RUN) && sat_i && !is_dup;
    assign stall     = want_push && full_after_pop;
    assign trial     = (state == RUN) && !stall;
    assign push      = want_push && !stall;

    assign trial_next  = trial_cnt + CNT_W'(1);
    assign accept_next = accept_cnt + CNT_W'(push);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= cand_o;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lanes      <= '0;
            trial_cnt  <= '0;
            accept_cnt <= '0;
            max_r      <= '0;
            target_r   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lanes      <= lanes_seed;
                        trial_cnt  <= '0;
                        accept_cnt <= '0;
                        max_r      <= max_trials;
                        target_r   <= target_accepts;
                        if (max_trials == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (trial) begin
                        trial_cnt  <= trial_next;
                        accept_cnt <= accept_next;
                        lanes      <= lanes_step;
                        if ((trial_next == max_r) ||
                            ((target_r != '0) && (accept_next == target_r))) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_sample_harvester.sv
// Self-checking bench for constraint_sample_harvester: random runs scored against a trial-sequence reference model.
module tb_constraint_sample_harvester;
    localparam int VEC_W      = 224;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 32;
    localparam int LANES      = (VEC_W + 31) / 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      seed_i;
    logic             start;
    logic [CNT_W-1:0] max_trials;
    logic [CNT_W-1:0] target_accepts;
    logic [VEC_W-1:0] cand_o;
    logic             sat_i;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] trial_cnt;
    logic [CNT_W-1:0] accept_cnt;

    int test_count = 0;
    int fail_count = 0;
    int sat_mode   = 0;
    int ready_mode = 0;
    int done_seen  = 0;
    int exp_trials = 0;
    int exp_accepts = 0;

    logic [VEC_W-1:0] exp_q[$];
    logic [VEC_W-1:0] trial_q[$];
    logic [31:0]      popped_lo[$];

    constraint_sample_harvester #(
        .VEC_W(VEC_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seed_i(seed_i),
        .start(start),
        .max_trials(max_trials),
        .target_accepts(target_accepts),
        .cand_o(cand_o),
        .sat_i(sat_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .done(done),
        .trial_cnt(trial_cnt),
        .accept_cnt(accept_cnt)
    );

    always #5 clk = ~clk;

    // Checker model standing in for the generated constraint logic.
    function automatic logic sat_of(input int mode, input logic [VEC_W-1:0] v);
        case (mode)
            0:       return 1'b1;
            1:       return v[0];
            default: return v[3] ^ v[100] ^ v[223];
        endcase
    endfunction

    assign sat_i = sat_of(sat_mode, cand_o);

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] expected);
        test_count++;
        if (got !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    function automatic logic [31:0] lfsrStep(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h8020_0003;
        return x >> 1;
    endfunction

    // Enumerate every trial the run should make and which candidates must come out of the FIFO.
    task automatic buildModel(input logic [31:0] seed, input int max_t, input int tgt);
        logic [31:0]         lane [LANES];
        logic [LANES*32-1:0] flat;
        logic [31:0]         kk;
        int                  accepts;
        accepts = 0;
        exp_q.delete();
        trial_q.delete();
        for (int k = 0; k < LANES; k++) begin
            kk = k;
            lane[k] = seed ^ (kk * 32'h9E37_79B9);
            if (lane[k] == 32'h0) lane[k] = 32'h1;
        end
        exp_trials = 0;
        while (exp_trials < max_t && !(tgt != 0 && accepts == tgt)) begin
            for (int k = 0; k < LANES; k++) flat[k*32 +: 32] = lane[k];
            trial_q.push_back(flat[VEC_W-1:0]);
            exp_trials++;
            if (sat_of(sat_mode, flat[VEC_W-1:0])) begin
                exp_q.push_back(flat[VEC_W-1:0]);
                accepts++;
            end
            for (int k = 0; k < LANES; k++) lane[k] = lfsrStep(lane[k]);
        end
        exp_accepts = accepts;
    endtask

    task automatic stepCycle();
        case (ready_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("pop_unexpected", {255'b0, out_valid}, 256'd0);
            end else begin
                checkOutput("fifo_data", {32'b0, out_data}, {32'b0, exp_q.pop_front()});
            end
            popped_lo.push_back(out_data[31:0]);
        end
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    task automatic applyStimulus(input logic [31:0] seed, input int max_t, input int tgt);
        buildModel(seed, max_t, tgt);
        done_seen = 0;
        popped_lo.delete();
        seed_i         = seed;
        max_trials     = CNT_W'(max_t);
        target_accepts = CNT_W'(tgt);
        start          = 1'b1;
        stepCycle();
        start          = 1'b0;
    endtask

    task automatic finishRun(input string tag);
        int n;
        n = 0;
        while (done_seen == 0 && n < 3000) begin
            stepCycle();
            n++;
        end
        repeat (3) stepCycle();
        checkOutput({tag, "_done_once"}, 256'(done_seen), 256'd1);
        checkOutput({tag, "_trials"}, 256'(trial_cnt), 256'(exp_trials));
        checkOutput({tag, "_accepts"}, 256'(accept_cnt), 256'(exp_accepts));
        checkOutput({tag, "_busy"}, 256'(busy), 256'd0);
        checkOutput({tag, "_undelivered"}, 256'(exp_q.size()), 256'd0);
        checkOutput({tag, "_valid"}, 256'(out_valid), 256'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        seed_i = '0;
        max_trials = '0;
        target_accepts = '0;
        out_ready = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rst_cand", {32'b0, cand_o}, 256'd0);
        checkOutput("rst_trials", 256'(trial_cnt), 256'd0);
        checkOutput("rst_accepts", 256'(accept_cnt), 256'd0);
        checkOutput("rst_valid", 256'(out_valid), 256'd0);
        checkOutput("rst_busy", 256'(busy), 256'd0);
        checkOutput("rst_done", 256'(done), 256'd0);
        rst = 1'b0;
        stepCycle();

        // Seed 1, always satisfied: lane 0 runs 0x1 then 0x80200003.
        sat_mode = 0;
        ready_mode = 0;
        applyStimulus(32'h1, 5, 0);
        repeat (5) stepCycle();
        checkOutput("t1_trials_5cyc", 256'(trial_cnt), 256'd5);
        checkOutput("t1_accepts_5cyc", 256'(accept_cnt), 256'd5);
        finishRun("t1");
        checkOutput("t1_first_lane0", 256'(popped_lo[0]), 256'h1);
        checkOutput("t1_second_lane0", 256'(popped_lo[1]), 256'h8020_0003);

        sat_mode = 1;
        ready_mode = 1;
        applyStimulus(32'hACE1, 100, 0);
        finishRun("t2");

        // Consumer blocked: the FIFO fills and trials freeze on the ninth candidate.
        sat_mode = 0;
        ready_mode = 2;
        applyStimulus(32'h1234_5678, 20, 0);
        repeat (15) stepCycle();
        checkOutput("t3_frozen_trials", 256'(trial_cnt), 256'd8);
        checkOutput("t3_frozen_accepts", 256'(accept_cnt), 256'd8);
        checkOutput("t3_busy", 256'(busy), 256'd1);
        checkOutput("t3_cand_held", {32'b0, cand_o}, {32'b0, trial_q[8]});
        ready_mode = 1;
        finishRun("t3");

        ready_mode = 0;
        applyStimulus(32'hDEAD_BEEF, 0, 0);
        checkOutput("t4_done_next", 256'(done), 256'd1);
        checkOutput("t4_valid", 256'(out_valid), 256'd0);
        finishRun("t4");

        applyStimulus(32'h0BAD_F00D, 1000, 3);
        finishRun("t5");

        // Reset mid-run with four entries queued, then replay the same seed.
        ready_mode = 2;
        applyStimulus(32'h5EED_0001, 20, 0);
        repeat (4) stepCycle();
        checkOutput("t6_accepts_before", 256'(accept_cnt), 256'd4);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("t6_valid", 256'(out_valid), 256'd0);
        checkOutput("t6_trials", 256'(trial_cnt), 256'd0);
        checkOutput("t6_accepts", 256'(accept_cnt), 256'd0);
        checkOutput("t6_busy", 256'(busy), 256'd0);
        checkOutput("t6_cand", {32'b0, cand_o}, 256'd0);
        ready_mode = 1;
        applyStimulus(32'h5EED_0001, 20, 0);
        finishRun("t6");

        for (int r = 0; r < 6; r++) begin
            sat_mode = int'($urandom_range(0, 2));
            ready_mode = 1;
            applyStimulus($urandom, int'($urandom_range(1, 60)), int'($urandom_range(0, 4)));
            finishRun("rand");
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
